// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo_if
//  Purpose  : Byte read handshake, error readout and fill level between the
//             UART receive FIFO (slave) and the command core (master).
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if #(
  parameter int ADDR_BITS = 4
) ();
  logic [7:0]         read_data_o;
  logic               read_valid_o;
  logic               read_ready_i;
  logic               clear_errors_i;
  logic               error_overflow_o;
  logic               error_framing_o;
  logic [ADDR_BITS:0] fill_level_o;

  // Consumer side: accepts bytes and clears errors.
  modport master (
    input  read_data_o, read_valid_o, error_overflow_o, error_framing_o, fill_level_o,
    output read_ready_i, clear_errors_i
  );

  // Receiver side: produces bytes, flags and the fill level.
  modport slave (
    output read_data_o, read_valid_o, error_overflow_o, error_framing_o, fill_level_o,
    input  read_ready_i, clear_errors_i
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo
//  Purpose  : 8N1 UART receiver feeding a first-word-fall-through byte FIFO,
//             with sticky overflow and framing error flags.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 104,
  parameter int ADDR_BITS    = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          rx,
  uart_rx_fifo_if.slave bus
);

  localparam int                 c_DEPTH = 1 << ADDR_BITS;
  localparam int                 c_TW    = $clog2(CLKS_PER_BIT);
  localparam logic [c_TW-1:0]    c_HALF  = c_TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_TW-1:0]    c_FULL  = c_TW'(CLKS_PER_BIT - 1);
  localparam logic [c_TW-1:0]    c_ONE   = c_TW'(1);
  localparam logic [ADDR_BITS:0] c_FILL_MAX = (ADDR_BITS + 1)'(c_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  // Receiver state
  logic                 r_rx_meta;
  logic                 r_rx_sync;
  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_TW-1:0]      r_timer;
  logic [c_TW-1:0]      w_timer_nxt;
  logic [2:0]           r_bit_idx;
  logic [2:0]           w_bit_idx_nxt;
  logic [7:0]           r_shift;
  logic [7:0]           w_shift_nxt;
  logic                 w_push;
  logic                 w_frame_err;

  // FIFO state
  logic [7:0]           r_mem [c_DEPTH];
  logic [ADDR_BITS-1:0] r_wr_ptr;
  logic [ADDR_BITS-1:0] r_rd_ptr;
  logic [ADDR_BITS:0]   r_fill;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push_ok;
  logic                 w_ovf_evt;

  // Sticky flags
  logic                 r_err_ovf;
  logic                 r_err_frm;

  // Two-flop synchroniser; preset high so reset looks like an idle line.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // Receiver state, bit timer, bit index and shift register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  // Frame sequencing: sample each bit mid-period, push on a good stop bit.
  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_push        = 1'b0;
    w_frame_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rx_sync) begin
          w_timer_nxt = c_HALF;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (r_timer == '0) begin
          if (!r_rx_sync) begin
            w_timer_nxt   = c_FULL;
            w_bit_idx_nxt = '0;
            w_state_nxt   = S_DATA;
          end else begin
            // Start bit gone by mid-period: line glitch, not a frame.
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_timer_nxt = r_timer - c_ONE;
        end
      end
      S_DATA: begin
        if (r_timer == '0) begin
          w_shift_nxt[r_bit_idx] = r_rx_sync;
          w_timer_nxt            = c_FULL;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_timer_nxt = r_timer - c_ONE;
        end
      end
      S_STOP: begin
        if (r_timer == '0) begin
          if (r_rx_sync) begin
            w_push      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_frame_err = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end else begin
          w_timer_nxt = r_timer - c_ONE;
        end
      end
      S_BREAK: begin
        // Wait out a held-low line so it yields a single framing error.
        if (r_rx_sync) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_full    = (r_fill == c_FILL_MAX);
  assign w_pop     = bus.read_valid_o && bus.read_ready_i;
  // When full, a same-cycle pop frees the slot the push writes into.
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_ovf_evt = w_push && w_full && !w_pop;

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= w_shift_nxt;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
    end
  end

  // Sticky error flags; a new event outranks a same-cycle clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_err_ovf <= 1'b0;
      r_err_frm <= 1'b0;
    end else begin
      if (w_ovf_evt) begin
        r_err_ovf <= 1'b1;
      end else if (bus.clear_errors_i) begin
        r_err_ovf <= 1'b0;
      end
      if (w_frame_err) begin
        r_err_frm <= 1'b1;
      end else if (bus.clear_errors_i) begin
        r_err_frm <= 1'b0;
      end
    end
  end

  assign bus.read_data_o      = r_mem[r_rd_ptr];
  assign bus.read_valid_o     = (r_fill != '0);
  assign bus.fill_level_o     = r_fill;
  assign bus.error_overflow_o = r_err_ovf;
  assign bus.error_framing_o  = r_err_frm;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_fifo
//  Purpose  : Self-checking bench for uart_rx_fifo (4 clocks/bit, depth 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  localparam int CPB = 4;
  localparam int AB  = 2;
  localparam int NRAND = 4;

  logic clock = 1'b0;
  logic reset;
  logic rx;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] model_q[$];

  uart_rx_fifo_if #(.ADDR_BITS(AB)) bus ();

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .ADDR_BITS(AB)) dut (
    .clock (clock),
    .reset (reset),
    .rx    (rx),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  // Drives one 8N1 frame; returns one step before the stop-bit sample edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    steps(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      steps(CPB);
    end
    rx = stop_bit;
    steps(CPB);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx = 1'b1;
    bus.read_ready_i = 1'b0;
    bus.clear_errors_i = 1'b0;
    steps(3);
    checks++; if (bus.read_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.read_valid_o); end
    checks++; if (bus.fill_level_o !== 3'd0) begin errors++; $display("FAIL reset_fill: got %0d expected 0", bus.fill_level_o); end
    checks++; if (bus.read_data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", bus.read_data_o); end
    checks++; if (bus.error_overflow_o !== 1'b0 || bus.error_framing_o !== 1'b0) begin errors++; $display("FAIL reset_errors: got ovf=%b frm=%b expected 0 0", bus.error_overflow_o, bus.error_framing_o); end
    reset = 1'b0;
    steps(5);
  endtask

  task automatic test_single_byte();
    bus.read_ready_i = 1'b1;
    send_frame(8'hA5, 1'b1);
    checks++; if (bus.read_valid_o !== 1'b0) begin errors++; $display("FAIL single_early: valid got %b expected 0", bus.read_valid_o); end
    step();
    checks++; if (bus.read_valid_o !== 1'b1 || bus.read_data_o !== 8'hA5) begin errors++; $display("FAIL single_data: got valid=%b data=%h expected 1 a5", bus.read_valid_o, bus.read_data_o); end
    step();
    checks++; if (bus.read_valid_o !== 1'b0 || bus.fill_level_o !== 3'd0) begin errors++; $display("FAIL single_drain: got valid=%b fill=%0d expected 0 0", bus.read_valid_o, bus.fill_level_o); end
    checks++; if (bus.error_overflow_o !== 1'b0 || bus.error_framing_o !== 1'b0) begin errors++; $display("FAIL single_errors: got ovf=%b frm=%b expected 0 0", bus.error_overflow_o, bus.error_framing_o); end
    bus.read_ready_i = 1'b0;
  endtask

  // Random bytes with random consumer stalls against a queue model.
  task automatic test_random_stream();
    logic       wave[$];
    logic [7:0] b;
    logic       pop_pending;
    int         total;
    wave = {};
    model_q = {};
    b = '0;
    for (int f = 0; f < NRAND; f++) begin
      b = 8'($urandom);
      for (int k = 0; k < CPB; k++) wave.push_back(1'b0);
      for (int i = 0; i < 8; i++)
        for (int k = 0; k < CPB; k++) wave.push_back(b[i]);
      for (int k = 0; k < CPB; k++) wave.push_back(1'b1);
    end
    total = 40 * NRAND + 20;
    for (int c = 0; c < total; c++) begin
      rx = (c < wave.size()) ? wave[c] : 1'b1;
      bus.read_ready_i = (c >= 40 * NRAND + 5) ? 1'b1 : 1'($urandom_range(0, 1));
      pop_pending = bus.read_ready_i && (model_q.size() != 0);
      step();
      if (pop_pending) void'(model_q.pop_front());
      if (c >= 40 && (c % 40) == 0 && (c / 40) <= NRAND) begin
        int f;
        f = c / 40 - 1;
        model_q.push_back({wave[40*f + 32], wave[40*f + 28], wave[40*f + 24], wave[40*f + 20],
                           wave[40*f + 16], wave[40*f + 12], wave[40*f + 8],  wave[40*f + 4]});
      end
      checks++; if (bus.fill_level_o !== 3'(model_q.size())) begin errors++; $display("FAIL rand_fill c=%0d: got %0d expected %0d", c, bus.fill_level_o, model_q.size()); end
      if (model_q.size() != 0) begin
        checks++; if (bus.read_valid_o !== 1'b1 || bus.read_data_o !== model_q[0]) begin errors++; $display("FAIL rand_head c=%0d: got valid=%b data=%h expected 1 %h", c, bus.read_valid_o, bus.read_data_o, model_q[0]); end
      end else begin
        checks++; if (bus.read_valid_o !== 1'b0) begin errors++; $display("FAIL rand_empty c=%0d: got valid=%b expected 0", c, bus.read_valid_o); end
      end
    end
    checks++; if (bus.error_overflow_o !== 1'b0 || bus.error_framing_o !== 1'b0) begin errors++; $display("FAIL rand_errors: got ovf=%b frm=%b expected 0 0", bus.error_overflow_o, bus.error_framing_o); end
    bus.read_ready_i = 1'b0;
  endtask

  task automatic test_overflow();
    logic [7:0] exp_drain [4];
    exp_drain = '{8'h02, 8'h03, 8'h04, 8'h06};
    bus.read_ready_i = 1'b0;
    for (int v = 1; v <= 4; v++) send_frame(8'(v), 1'b1);
    step();
    checks++; if (bus.fill_level_o !== 3'd4) begin errors++; $display("FAIL ovf_fill4: got %0d expected 4", bus.fill_level_o); end
    send_frame(8'h05, 1'b1);
    step();
    checks++; if (bus.error_overflow_o !== 1'b1 || bus.fill_level_o !== 3'd4) begin errors++; $display("FAIL ovf_set: got ovf=%b fill=%0d expected 1 4", bus.error_overflow_o, bus.fill_level_o); end
    checks++; if (bus.read_data_o !== 8'h01) begin errors++; $display("FAIL ovf_head_stable: got %h expected 01", bus.read_data_o); end
    bus.clear_errors_i = 1'b1;
    step();
    bus.clear_errors_i = 1'b0;
    checks++; if (bus.error_overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", bus.error_overflow_o); end
    // Pop on the exact push edge of 0x06.
    send_frame(8'h06, 1'b1);
    bus.read_ready_i = 1'b1;
    checks++; if (bus.read_data_o !== 8'h01) begin errors++; $display("FAIL full_pop_head: got %h expected 01", bus.read_data_o); end
    step();
    bus.read_ready_i = 1'b0;
    checks++; if (bus.error_overflow_o !== 1'b0 || bus.fill_level_o !== 3'd4) begin errors++; $display("FAIL full_pop: got ovf=%b fill=%0d expected 0 4", bus.error_overflow_o, bus.fill_level_o); end
    // Clear on the same edge as an overflow: the set must win.
    send_frame(8'h07, 1'b1);
    bus.clear_errors_i = 1'b1;
    step();
    bus.clear_errors_i = 1'b0;
    checks++; if (bus.error_overflow_o !== 1'b1 || bus.fill_level_o !== 3'd4) begin errors++; $display("FAIL set_beats_clear: got ovf=%b fill=%0d expected 1 4", bus.error_overflow_o, bus.fill_level_o); end
    bus.read_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.read_valid_o !== 1'b1 || bus.read_data_o !== exp_drain[i]) begin errors++; $display("FAIL drain_%0d: got valid=%b data=%h expected 1 %h", i, bus.read_valid_o, bus.read_data_o, exp_drain[i]); end
      step();
    end
    bus.read_ready_i = 1'b0;
    checks++; if (bus.read_valid_o !== 1'b0 || bus.fill_level_o !== 3'd0) begin errors++; $display("FAIL drain_empty: got valid=%b fill=%0d expected 0 0", bus.read_valid_o, bus.fill_level_o); end
    bus.clear_errors_i = 1'b1;
    step();
    bus.clear_errors_i = 1'b0;
  endtask

  task automatic test_framing();
    send_frame(8'h3C, 1'b0);
    step();
    checks++; if (bus.error_framing_o !== 1'b1 || bus.fill_level_o !== 3'd0) begin errors++; $display("FAIL frm_set: got frm=%b fill=%0d expected 1 0", bus.error_framing_o, bus.fill_level_o); end
    steps(10);
    bus.clear_errors_i = 1'b1;
    step();
    bus.clear_errors_i = 1'b0;
    checks++; if (bus.error_framing_o !== 1'b0) begin errors++; $display("FAIL frm_clear: got %b expected 0", bus.error_framing_o); end
    steps(30);
    checks++; if (bus.error_framing_o !== 1'b0 || bus.fill_level_o !== 3'd0) begin errors++; $display("FAIL frm_break_once: got frm=%b fill=%0d expected 0 0", bus.error_framing_o, bus.fill_level_o); end
    rx = 1'b1;
    steps(8);
    send_frame(8'h7E, 1'b1);
    step();
    checks++; if (bus.read_valid_o !== 1'b1 || bus.read_data_o !== 8'h7E || bus.error_framing_o !== 1'b0) begin errors++; $display("FAIL frm_next: got valid=%b data=%h frm=%b expected 1 7e 0", bus.read_valid_o, bus.read_data_o, bus.error_framing_o); end
    bus.read_ready_i = 1'b1;
    step();
    bus.read_ready_i = 1'b0;
    checks++; if (bus.fill_level_o !== 3'd0) begin errors++; $display("FAIL frm_drain: got %0d expected 0", bus.fill_level_o); end
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    step();
    rx = 1'b1;
    steps(20);
    checks++; if (bus.read_valid_o !== 1'b0 || bus.fill_level_o !== 3'd0) begin errors++; $display("FAIL glitch_byte: got valid=%b fill=%0d expected 0 0", bus.read_valid_o, bus.fill_level_o); end
    checks++; if (bus.error_framing_o !== 1'b0 || bus.error_overflow_o !== 1'b0) begin errors++; $display("FAIL glitch_errors: got frm=%b ovf=%b expected 0 0", bus.error_framing_o, bus.error_overflow_o); end
  endtask

  task automatic test_reset_mid_frame();
    bus.read_ready_i = 1'b0;
    send_frame(8'h11, 1'b1);
    step();
    checks++; if (bus.read_valid_o !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %b expected 1", bus.read_valid_o); end
    rx = 1'b0;
    steps(CPB);
    rx = 1'b1;
    steps(3 * CPB + 2);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.read_valid_o !== 1'b0 || bus.fill_level_o !== 3'd0 || bus.read_data_o !== 8'h00) begin errors++; $display("FAIL rst_async: got valid=%b fill=%0d data=%h expected 0 0 00", bus.read_valid_o, bus.fill_level_o, bus.read_data_o); end
    steps(2);
    rx = 1'b1;
    reset = 1'b0;
    steps(10);
    checks++; if (bus.read_valid_o !== 1'b0) begin errors++; $display("FAIL rst_partial: got valid=%b expected 0", bus.read_valid_o); end
    send_frame(8'h42, 1'b1);
    step();
    checks++; if (bus.read_valid_o !== 1'b1 || bus.read_data_o !== 8'h42 || bus.fill_level_o !== 3'd1) begin errors++; $display("FAIL rst_next: got valid=%b data=%h fill=%0d expected 1 42 1", bus.read_valid_o, bus.read_data_o, bus.fill_level_o); end
    checks++; if (bus.error_framing_o !== 1'b0 || bus.error_overflow_o !== 1'b0) begin errors++; $display("FAIL rst_errors: got frm=%b ovf=%b expected 0 0", bus.error_framing_o, bus.error_overflow_o); end
    bus.read_ready_i = 1'b1;
    step();
    bus.read_ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_random_stream();
    test_overflow();
    test_framing();
    test_glitch();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
